// File: rtl/hpdcache_ace_snoop_seq.sv
// ACE snoop sequencer: limits how many snoops are outstanding, gates CR/CD toward the interconnect,
// regenerates CD last from a beat counter and latches protocol errors.
module hpdcache_ace_snoop_seq #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned BeatsPerLine   = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1),
  parameter int unsigned BeatWidth      = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ac_valid_i,
  output logic                ac_ready_o,
  output logic                ac_valid_o,
  input  logic                ac_ready_i,
  input  logic                cr_valid_i,
  input  logic                cr_data_transfer_i,
  output logic                cr_ready_o,
  output logic                cr_valid_o,
  input  logic                cr_ready_i,
  input  logic                cd_valid_i,
  input  logic                cd_last_i,
  output logic                cd_ready_o,
  output logic                cd_valid_o,
  output logic                cd_last_o,
  input  logic                cd_ready_i,
  output logic [CntWidth-1:0] occupancy_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0]  MaxCnt   = CntWidth'(MaxOutstanding);
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(BeatsPerLine - 1);

  logic [CntWidth-1:0]  occ, dp;
  logic [BeatWidth-1:0] bc;
  logic                 err;

  logic ac_ok, cr_ok, cd_ok;
  logic ac_hs, cr_hs, cd_hs;
  logic dp_inc, dp_dec, err_set;

  assign ac_ok = occ < MaxCnt;
  // A data-carrying CR must wait while every data slot is still draining.
  assign cr_ok = (occ != '0) & ~(cr_data_transfer_i & (dp == MaxCnt));
  assign cd_ok = dp != '0;

  assign ac_valid_o = ac_valid_i & ac_ok;
  assign ac_ready_o = ac_ready_i & ac_ok;
  assign cr_valid_o = cr_valid_i & cr_ok;
  assign cr_ready_o = cr_ready_i & cr_ok;
  assign cd_valid_o = cd_valid_i & cd_ok;
  assign cd_ready_o = cd_ready_i & cd_ok;
  assign cd_last_o  = bc == LastBeat;

  assign ac_hs = ac_valid_i & ac_ready_o;
  assign cr_hs = cr_valid_o & cr_ready_i;
  assign cd_hs = cd_valid_o & cd_ready_i;

  assign dp_inc = cr_hs & cr_data_transfer_i;
  assign dp_dec = cd_hs & cd_last_o;

  assign err_set = (cr_valid_i & (occ == '0))
                 | (cd_hs & (cd_last_i != cd_last_o))
                 | (cd_valid_i & (dp == '0) & (bc == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ <= '0;
      dp  <= '0;
      bc  <= '0;
      err <= 1'b0;
    end else begin
      case ({ac_hs, cr_hs})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      case ({dp_inc, dp_dec})
        2'b10:   dp <= dp + 1'b1;
        2'b01:   dp <= dp - 1'b1;
        default: dp <= dp;
      endcase
      if (cd_hs) bc <= (bc == LastBeat) ? '0 : bc + 1'b1;
      if (err_set) err <= 1'b1;
    end
  end

  assign occupancy_o = occ;
  assign busy_o      = (occ != '0) | (dp != '0) | (bc != '0);
  assign err_o       = err;

endmodule

// File: tb/tb_hpdcache_ace_snoop_seq.sv
// Directed bench for hpdcache_ace_snoop_seq with hand-computed expectations (default parameters).
module tb_hpdcache_ace_snoop_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ac_valid_i, ac_ready_i, ac_ready_o, ac_valid_o;
  logic       cr_valid_i, cr_data_transfer_i, cr_ready_o, cr_valid_o, cr_ready_i;
  logic       cd_valid_i, cd_last_i, cd_ready_o, cd_valid_o, cd_last_o, cd_ready_i;
  logic [2:0] occupancy_o;
  logic       busy_o, err_o;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk_i = ~clk_i;

  hpdcache_ace_snoop_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
    .cr_valid_i(cr_valid_i), .cr_data_transfer_i(cr_data_transfer_i), .cr_ready_o(cr_ready_o),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i),
    .cd_valid_i(cd_valid_i), .cd_last_i(cd_last_i), .cd_ready_o(cd_ready_o), .cd_valid_o(cd_valid_o),
    .cd_last_o(cd_last_o), .cd_ready_i(cd_ready_i),
    .occupancy_o(occupancy_o), .busy_o(busy_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ac_hs();
    ac_valid_i = 1'b1;
    step();
    ac_valid_i = 1'b0;
  endtask

  task automatic cr_hs(input logic dt);
    cr_valid_i = 1'b1;
    cr_data_transfer_i = dt;
    step();
    cr_valid_i = 1'b0;
    cr_data_transfer_i = 1'b0;
  endtask

  task automatic send_line();
    cd_valid_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cd_last_i = (b == 3);
      step();
    end
    cd_valid_i = 1'b0;
    cd_last_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    ac_valid_i = 0; ac_ready_i = 1;
    cr_valid_i = 0; cr_data_transfer_i = 0; cr_ready_i = 1;
    cd_valid_i = 0; cd_last_i = 0; cd_ready_i = 1;
    #1;
    chk("rst_ac_ready", ac_ready_o, 1);
    chk("rst_cr_ready", cr_ready_o, 0);
    chk("rst_cd_ready", cd_ready_o, 0);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    step();
    rst_ni = 1'b1;

    // Fill to the outstanding cap.
    for (int i = 1; i <= 4; i++) begin
      ac_hs();
      chk("fill_occ", occupancy_o, i);
    end
    ac_valid_i = 1'b1;
    #1;
    chk("cap_ac_ready", ac_ready_o, 0);
    chk("cap_ac_valid", ac_valid_o, 0);
    step();
    chk("cap_occ_hold", occupancy_o, 4);
    // CR frees one slot while AC is blocked; then simultaneous AC+CR keeps the count.
    cr_valid_i = 1'b1;
    #1;
    chk("cap_cr_ready", cr_ready_o, 1);
    step();
    chk("cr_only_occ", occupancy_o, 3);
    chk("reopen_ac_ready", ac_ready_o, 1);
    step();
    chk("ac_cr_same_occ", occupancy_o, 3);
    cr_valid_i = 1'b0;
    step();
    chk("refill_occ", occupancy_o, 4);
    ac_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cr_hs(1'b0);
    chk("drain_occ", occupancy_o, 0);
    chk("drain_busy", busy_o, 0);
    chk("drain_err", err_o, 0);

    // One data snoop, CD with toggling ready.
    ac_hs();
    cr_hs(1'b1);
    chk("data_occ", occupancy_o, 0);
    chk("data_busy", busy_o, 1);
    begin
      int beat = 0;
      cd_valid_i = 1'b1;
      for (int k = 0; k < 7; k++) begin
        cd_ready_i = (k % 2 == 0);
        cd_last_i  = (beat == 3);
        #1;
        chk("tog_cd_valid", cd_valid_o, 1);
        if (cd_ready_i) chk("tog_cd_last", cd_last_o, (beat == 3));
        if (k == 6) chk("tog_busy_before", busy_o, 1);
        step();
        if (k % 2 == 0) beat++;
      end
    end
    cd_valid_i = 1'b0;
    cd_last_i  = 1'b0;
    chk("tog_busy_after", busy_o, 0);
    cd_ready_i = 1'b1;
    #1;
    chk("tog_dp_zero", cd_ready_o, 0);
    step();
    chk("tog_err", err_o, 0);

    // CD presented before its CR.
    ac_hs();
    cd_valid_i = 1'b1;
    cd_last_i  = 1'b0;
    #1;
    chk("early_cd_valid", cd_valid_o, 0);
    chk("early_cd_ready", cd_ready_o, 0);
    step();
    chk("early_err", err_o, 1);
    cr_hs(1'b1);
    chk("late_cd_valid", cd_valid_o, 1);
    send_line();
    chk("early_busy", busy_o, 0);
    chk("early_err_sticky", err_o, 1);

    // Wrong last on beat 2 of 4.
    do_reset();
    chk("re_rst_err", err_o, 0);
    ac_hs();
    cr_hs(1'b1);
    cd_valid_i = 1'b1;
    cd_last_i  = 1'b0;
    step();
    cd_last_i = 1'b1;
    #1;
    chk("badlast_cd_last", cd_last_o, 0);
    chk("badlast_err_pre", err_o, 0);
    step();
    chk("badlast_err", err_o, 1);
    cd_last_i = 1'b0;
    step();
    cd_last_i = 1'b1;
    step();
    cd_valid_i = 1'b0;
    cd_last_i  = 1'b0;
    step(); step(); step();
    chk("badlast_sticky", err_o, 1);
    chk("badlast_busy", busy_o, 0);
    rst_ni = 1'b0;
    #1;
    chk("badlast_rst_clear", err_o, 0);
    step();
    rst_ni = 1'b1;

    // Data slots full: data CR stalls, non-data CR passes.
    for (int i = 0; i < 4; i++) ac_hs();
    for (int i = 0; i < 4; i++) cr_hs(1'b1);
    chk("full_occ", occupancy_o, 0);
    ac_hs();
    cr_valid_i = 1'b1;
    cr_data_transfer_i = 1'b1;
    #1;
    chk("full_cr_ready", cr_ready_o, 0);
    chk("full_cr_valid", cr_valid_o, 0);
    step();
    chk("full_stall_occ", occupancy_o, 1);
    cr_data_transfer_i = 1'b0;
    #1;
    chk("nodata_cr_ready", cr_ready_o, 1);
    step();
    cr_valid_i = 1'b0;
    chk("nodata_occ", occupancy_o, 0);
    chk("full_busy", busy_o, 1);
    chk("full_err", err_o, 0);
    // Draining one line frees a data slot again.
    send_line();
    ac_hs();
    cr_valid_i = 1'b1;
    cr_data_transfer_i = 1'b1;
    #1;
    chk("freed_cr_ready", cr_ready_o, 1);
    step();
    cr_valid_i = 1'b0;
    cr_data_transfer_i = 1'b0;
    chk("freed_occ", occupancy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
